// File: rtl/reset_sequencer_if.sv
// Handshake bundle between a reset_sequencer and its requesters/consumers.
// The master side drives the control inputs; the slave side is the sequencer.
interface reset_sequencer_if #(
  parameter int unsigned N      = 4,
  parameter int unsigned M_BITS = 8
);

  logic              start;
  logic [N-1:0]      req;
  logic [M_BITS-1:0] hold_m;
  logic [M_BITS-1:0] gap_m;
  logic [N-1:0]      en;
  logic [N-1:0]      grant;
  logic              busy;
  logic              done;

  modport master (
    output start,
    output req,
    output hold_m,
    output gap_m,
    input  en,
    input  grant,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  req,
    input  hold_m,
    input  gap_m,
    output en,
    output grant,
    output busy,
    output done
  );

endinterface

// File: rtl/reset_sequencer.sv
// Staged power-up reset release across N channels, followed by round-robin
// single-channel re-reset service. All outputs are registered.
module reset_sequencer #(
  parameter int unsigned N      = 4,
  parameter int unsigned M_BITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  reset_sequencer_if.slave bus
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] S_HELD     = 3'd0;
  localparam logic [2:0] S_SEQ_HOLD = 3'd1;
  localparam logic [2:0] S_SEQ_GAP  = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_REQ_HOLD = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [M_BITS-1:0] cnt_q, cnt_d;
  logic [M_BITS-1:0] hold_q, hold_d;
  logic [M_BITS-1:0] gap_q, gap_d;
  logic [IW-1:0]     ch_q, ch_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [N-1:0]      en_q, en_d;
  logic [N-1:0]      grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [M_BITS-1:0] hold_s;
  logic [M_BITS-1:0] gap_s;
  logic              win;
  logic [IW-1:0]     win_idx;
  int unsigned       cand;

  // Zero durations are promoted to one; round-robin search starts at ptr_q.
  always_comb begin
    hold_s  = (bus.hold_m == '0) ? M_BITS'(1) : bus.hold_m;
    gap_s   = (bus.gap_m == '0) ? M_BITS'(1) : bus.gap_m;
    win     = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = 32'(ptr_q) + off;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!win && bus.req[IW'(cand)]) begin
        win     = 1'b1;
        win_idx = IW'(cand);
      end
    end
  end

  // Next-state and next-output logic; counter counts up to latched length - 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    en_d    = en_q;
    grant_d = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_HELD: begin
        en_d = '1;
        if (bus.start) begin
          state_d = S_SEQ_HOLD;
          hold_d  = hold_s;
          gap_d   = gap_s;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end

      S_SEQ_HOLD: begin
        busy_d = 1'b1;
        if (cnt_q == hold_q - M_BITS'(1)) begin
          en_d[0] = 1'b0;
          ch_d    = IW'(1);
          cnt_d   = '0;
          state_d = S_SEQ_GAP;
        end else begin
          cnt_d = cnt_q + M_BITS'(1);
        end
      end

      S_SEQ_GAP: begin
        busy_d = 1'b1;
        if (cnt_q == gap_q - M_BITS'(1)) begin
          en_d[ch_q] = 1'b0;
          cnt_d      = '0;
          if (ch_q == IW'(N - 1)) begin
            state_d = S_RUN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            ch_d = ch_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + M_BITS'(1);
        end
      end

      S_RUN: begin
        en_d = '0;
        // A start request outranks any pending channel request.
        if (bus.start) begin
          state_d = S_SEQ_HOLD;
          hold_d  = hold_s;
          gap_d   = gap_s;
          cnt_d   = '0;
          en_d    = '1;
          busy_d  = 1'b1;
        end else if (win) begin
          state_d          = S_REQ_HOLD;
          hold_d           = hold_s;
          cnt_d            = '0;
          ch_d             = win_idx;
          en_d[win_idx]    = 1'b1;
          grant_d[win_idx] = 1'b1;
          busy_d           = 1'b1;
          ptr_d            = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
        end
      end

      S_REQ_HOLD: begin
        busy_d = 1'b1;
        if (cnt_q == hold_q - M_BITS'(1)) begin
          en_d[ch_q] = 1'b0;
          cnt_d      = '0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = S_RUN;
        end else begin
          cnt_d = cnt_q + M_BITS'(1);
        end
      end

      default: begin
        state_d = S_HELD;
        en_d    = '1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_HELD;
      cnt_q   <= '0;
      hold_q  <= '0;
      gap_q   <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
      en_q    <= '1;
      grant_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      en_q    <= en_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.en    = en_q;
  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: vector table, directed corner sequences and
// random stimulus checked against a timeline model of release/grant cycles.
module tb_reset_sequencer;

  localparam int N = 4;
  localparam int M = 8;
  localparam int NROWS = 22;

  logic clk = 1'b0;
  logic reset;

  reset_sequencer_if #(.N(N), .M_BITS(M)) bus ();

  reset_sequencer #(.N(N), .M_BITS(M)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [3:0] req;
    logic [7:0] hold_m;
    logic [7:0] gap_m;
    logic [3:0] en;
    logic [3:0] grant;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl [NROWS];

  int checks;
  int errors;
  int cyc;

  // Timeline model: an operation is remembered by its start edge and lengths.
  bit   m_held;
  int   m_kind;   // 0 none, 1 power-up sequence, 2 single-channel grant
  int   m_k;
  int   m_h;
  int   m_g;
  int   m_ch;
  int   m_end;    // cycle carrying the done pulse
  int   m_ptr;
  logic [3:0] x_en;
  logic [3:0] x_grant;
  logic       x_busy;
  logic       x_done;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nz(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_edge();
    int  c;
    bit  idle;
    bit  found;
    int  sel;
    int  j;
    if (!reset) begin
      m_held = 1'b1;
      m_kind = 0;
      m_ptr  = 0;
    end else begin
      idle = (m_kind == 0) || (cyc >= m_end);
      if (idle && bus.start) begin
        m_held = 1'b0;
        m_kind = 1;
        m_k    = cyc;
        m_h    = nz(int'(bus.hold_m));
        m_g    = nz(int'(bus.gap_m));
        m_end  = cyc + 1 + m_h + (N - 1) * m_g;
      end else if (idle && !m_held && bus.req != 4'b0000) begin
        found = 1'b0;
        sel   = 0;
        for (int o = 0; o < N; o++) begin
          j = (m_ptr + o) % N;
          if (!found && bus.req[j[1:0]]) begin
            found = 1'b1;
            sel   = j;
          end
        end
        m_kind = 2;
        m_k    = cyc;
        m_h    = nz(int'(bus.hold_m));
        m_ch   = sel;
        m_end  = cyc + m_h + 1;
        m_ptr  = (sel + 1) % N;
      end
    end

    c       = cyc + 1;
    x_en    = 4'b0000;
    x_grant = 4'b0000;
    x_busy  = 1'b0;
    x_done  = 1'b0;
    if (m_held) begin
      x_en = 4'b1111;
    end else if (m_kind == 1) begin
      for (int q = 0; q < N; q++) begin
        x_en[q[1:0]] = (c < m_k + 1 + m_h + q * m_g);
      end
      x_busy = (c < m_end);
      x_done = (c == m_end);
    end else if (m_kind == 2) begin
      if (c <= m_k + m_h) begin
        x_en[m_ch[1:0]] = 1'b1;
        x_busy          = 1'b1;
      end
      if (c == m_k + 1) begin
        x_grant[m_ch[1:0]] = 1'b1;
      end
      x_done = (c == m_end);
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_en", int'(bus.en), int'(x_en));
    chk("model_grant", int'(bus.grant), int'(x_grant));
    chk("model_busy", int'(bus.busy), int'(x_busy));
    chk("model_done", int'(bus.done), int'(x_done));
  endtask

  task automatic run_until_done(input int limit, input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < limit && !seen; n++) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    chk(name, int'(seen), 1);
  endtask

  task automatic row(input int i, input logic s, input logic [3:0] r, input int h, input int g,
                     input logic [3:0] e, input logic [3:0] gr, input logic b, input logic d);
    tbl[i].start  = s;
    tbl[i].req    = r;
    tbl[i].hold_m = 8'(h);
    tbl[i].gap_m  = 8'(g);
    tbl[i].en     = e;
    tbl[i].grant  = gr;
    tbl[i].busy   = b;
    tbl[i].done   = d;
  endtask

  task automatic hold_len(input int h, input int exp_len, input string name);
    int  cnt;
    bit  seen;
    bus.req    = 4'b0100;
    bus.hold_m = 8'(h);
    tick();
    chk({name, "_grant"}, int'(bus.grant), 4'b0100);
    bus.req = 4'b0000;
    cnt  = bus.en[2] ? 1 : 0;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      tick();
      if (bus.done) seen = 1'b1;
      else if (bus.en[2]) cnt++;
    end
    chk({name, "_done"}, int'(seen), 1);
    chk({name, "_len"}, cnt, exp_len);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    m_held = 1'b1;
    m_kind = 0;
    m_ptr  = 0;
    m_end  = 0;
    m_k    = 0;
    m_h    = 1;
    m_g    = 1;
    m_ch   = 0;
    bus.start  = 1'b0;
    bus.req    = 4'b0000;
    bus.hold_m = 8'd0;
    bus.gap_m  = 8'd0;

    // Asynchronous reset before any clock edge.
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_en", int'(bus.en), 4'hF);
    chk("rst_grant", int'(bus.grant), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    tick();
    tick();
    reset = 1'b1;

    // Held state ignores requests for 20 cycles.
    bus.req = 4'b1111;
    for (int n = 0; n < 20; n++) tick();
    chk("held_en", int'(bus.en), 4'hF);
    chk("held_grant", int'(bus.grant), 0);
    chk("held_busy", int'(bus.busy), 0);
    bus.req = 4'b0000;

    // Power-up sequence H=3 G=2, then round-robin over req=1010.
    row(0,  1'b0, 4'b1111, 3, 2, 4'b1111, 4'b0000, 1'b0, 1'b0);
    row(1,  1'b1, 4'b0000, 3, 2, 4'b1111, 4'b0000, 1'b1, 1'b0);
    row(2,  1'b0, 4'b0000, 9, 7, 4'b1111, 4'b0000, 1'b1, 1'b0);
    row(3,  1'b1, 4'b0100, 9, 7, 4'b1111, 4'b0000, 1'b1, 1'b0);
    row(4,  1'b0, 4'b0100, 9, 7, 4'b1110, 4'b0000, 1'b1, 1'b0);
    row(5,  1'b0, 4'b0100, 9, 7, 4'b1110, 4'b0000, 1'b1, 1'b0);
    row(6,  1'b0, 4'b0100, 3, 2, 4'b1100, 4'b0000, 1'b1, 1'b0);
    row(7,  1'b0, 4'b0100, 3, 2, 4'b1100, 4'b0000, 1'b1, 1'b0);
    row(8,  1'b0, 4'b0100, 3, 2, 4'b1000, 4'b0000, 1'b1, 1'b0);
    row(9,  1'b0, 4'b0100, 3, 2, 4'b1000, 4'b0000, 1'b1, 1'b0);
    row(10, 1'b0, 4'b0100, 3, 2, 4'b0000, 4'b0000, 1'b0, 1'b1);
    row(11, 1'b0, 4'b0000, 2, 2, 4'b0000, 4'b0000, 1'b0, 1'b0);
    row(12, 1'b0, 4'b1010, 2, 2, 4'b0010, 4'b0010, 1'b1, 1'b0);
    row(13, 1'b1, 4'b1010, 2, 2, 4'b0010, 4'b0000, 1'b1, 1'b0);
    row(14, 1'b0, 4'b1010, 2, 2, 4'b0000, 4'b0000, 1'b0, 1'b1);
    row(15, 1'b0, 4'b1010, 2, 2, 4'b1000, 4'b1000, 1'b1, 1'b0);
    row(16, 1'b0, 4'b1010, 2, 2, 4'b1000, 4'b0000, 1'b1, 1'b0);
    row(17, 1'b0, 4'b1010, 2, 2, 4'b0000, 4'b0000, 1'b0, 1'b1);
    row(18, 1'b0, 4'b1010, 2, 2, 4'b0010, 4'b0010, 1'b1, 1'b0);
    row(19, 1'b0, 4'b0000, 2, 2, 4'b0010, 4'b0000, 1'b1, 1'b0);
    row(20, 1'b0, 4'b0000, 2, 2, 4'b0000, 4'b0000, 1'b0, 1'b1);
    row(21, 1'b0, 4'b0000, 2, 2, 4'b0000, 4'b0000, 1'b0, 1'b0);

    for (int r = 0; r < NROWS; r++) begin
      bus.start  = tbl[r].start;
      bus.req    = tbl[r].req;
      bus.hold_m = tbl[r].hold_m;
      bus.gap_m  = tbl[r].gap_m;
      tick();
      chk($sformatf("row%0d_en", r), int'(bus.en), int'(tbl[r].en));
      chk($sformatf("row%0d_grant", r), int'(bus.grant), int'(tbl[r].grant));
      chk($sformatf("row%0d_busy", r), int'(bus.busy), int'(tbl[r].busy));
      chk($sformatf("row%0d_done", r), int'(bus.done), int'(tbl[r].done));
    end

    // Start and req together in RUN: start wins, req[0] served after done.
    bus.start  = 1'b1;
    bus.req    = 4'b0001;
    bus.hold_m = 8'd2;
    bus.gap_m  = 8'd1;
    tick();
    bus.start = 1'b0;
    chk("start_win_grant", int'(bus.grant), 0);
    chk("start_win_en", int'(bus.en), 4'hF);
    run_until_done(100, "start_win_seq_done");
    tick();
    chk("post_seq_grant", int'(bus.grant), 4'b0001);
    bus.req = 4'b0000;
    run_until_done(100, "post_seq_grant_done");

    // Hold length extremes on channel 2.
    hold_len(0, 1, "hold0");
    hold_len(255, 255, "hold255");

    // Reset during the gap phase aborts immediately and clears the pointer.
    bus.start  = 1'b1;
    bus.hold_m = 8'd1;
    bus.gap_m  = 8'd5;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("gap_phase_en", int'(bus.en), 4'b1110);
    #2 reset = 1'b0;
    #1;
    chk("async_en", int'(bus.en), 4'hF);
    chk("async_busy", int'(bus.busy), 0);
    chk("async_done", int'(bus.done), 0);
    tick();
    tick();
    reset   = 1'b1;
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) tick();
    bus.req    = 4'b0000;
    bus.start  = 1'b1;
    bus.hold_m = 8'd1;
    bus.gap_m  = 8'd1;
    tick();
    bus.start = 1'b0;
    run_until_done(50, "resume_seq_done");
    bus.req = 4'b1111;
    tick();
    chk("ptr_after_reset", int'(bus.grant), 4'b0001);
    bus.req = 4'b0000;
    run_until_done(50, "ptr_after_reset_done");

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bus.start  = ($urandom_range(0, 29) == 0);
      bus.req    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      bus.hold_m = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
      bus.gap_m  = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b0;
        tick();
        reset = 1'b1;
      end else begin
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
